// File: rtl/ste_snd_fifo.sv
// STE DMA-sound sample FIFO: buffers 16-bit MCU sound words and paces them out as signed
// left/right samples at a programmable rate. Define STE_SND_MONO_EN to honour the mono input.
module ste_snd_fifo #(
    parameter int DEPTH    = 4,
    parameter int DIV_BASE = 160
) (
    input  logic                   clk,
    input  logic                   porb,
    input  logic                   sndon,
    input  logic                   mono,
    input  logic [1:0]             rate,
    input  logic                   sload_n,
    input  logic [15:0]            data,
    output logic                   sreq,
    output logic [7:0]             left,
    output logic [7:0]             right,
    output logic                   sample_stb,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   unf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DIV_BASE * 8);

    function automatic logic [CNT_W-1:0] div_reload(input logic [1:0] r);
        logic [31:0] n;
        n = 32'(DIV_BASE) << (2'd3 - r);
        return CNT_W'(n - 32'd1);
    endfunction

    logic             sload_prev_q, sload_prev_d;
    logic             on_q, on_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [7:0]       left_q, left_d;
    logic [7:0]       right_q, right_d;
    logic             stb_q, stb_d;
    logic             sreq_q, sreq_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             push_edge_s, tick_s, empty_s, full_s, pop_s, push_s, drop_s;
    logic [15:0]      rd_word_s;

    assign push_edge_s = sload_prev_q & ~sload_n;
    assign tick_s      = sndon & on_q & (cnt_q == CNT_W'(0));
    assign empty_s     = (level_q == LVL_W'(0));
    assign full_s      = (level_q == LVL_W'(DEPTH));
    assign rd_word_s   = mem_q[rd_ptr_q];
    assign push_s      = sndon & push_edge_s & (~full_s | pop_s);
    assign drop_s      = sndon & push_edge_s & full_s & ~pop_s;

`ifdef STE_SND_MONO_EN
    logic phase_q, phase_d;
    // In mono the high-byte phase emits a sample without consuming the word.
    assign pop_s = tick_s & ~empty_s & (~mono | phase_q);
`else
    logic unused_mono_s;
    assign unused_mono_s = mono;
    assign pop_s = tick_s & ~empty_s;
`endif

    // Next-state logic: push/pop bookkeeping, rate divider, sample registers and sticky flags.
    always_comb begin
        sload_prev_d = sload_n;
        on_d         = sndon;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        mem_d        = mem_q;
        left_d       = left_q;
        right_d      = right_q;
        stb_d        = 1'b0;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
`ifdef STE_SND_MONO_EN
        phase_d      = phase_q;
`endif
        if (!sndon) begin
            cnt_d    = div_reload(rate);
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            level_d  = LVL_W'(0);
            left_d   = 8'h00;
            right_d  = 8'h00;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
`ifdef STE_SND_MONO_EN
            phase_d  = 1'b0;
`endif
        end else begin
            // Holding the reload on the first enabled edge makes the first tick land N edges later.
            if (!on_q || tick_s) begin
                cnt_d = div_reload(rate);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (push_s) begin
                mem_d[wr_ptr_q] = data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (tick_s && empty_s) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
            if (tick_s && !empty_s) begin
                stb_d = 1'b1;
`ifdef STE_SND_MONO_EN
                if (mono && !phase_q) begin
                    left_d  = rd_word_s[15:8];
                    right_d = rd_word_s[15:8];
                    phase_d = 1'b1;
                end else if (mono) begin
                    left_d  = rd_word_s[7:0];
                    right_d = rd_word_s[7:0];
                    phase_d = 1'b0;
                end else begin
                    left_d  = rd_word_s[15:8];
                    right_d = rd_word_s[7:0];
                    phase_d = 1'b0;
                end
`else
                left_d  = rd_word_s[15:8];
                right_d = rd_word_s[7:0];
`endif
            end else begin
                stb_d = 1'b0;
            end
        end
        sreq_d = sndon & (level_d <= LVL_W'(DEPTH - 2));
    end

    // State registers; porb clears everything asynchronously.
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            sload_prev_q <= 1'b1;
            on_q         <= 1'b0;
            cnt_q        <= div_reload(2'b00);
            wr_ptr_q     <= PTR_W'(0);
            rd_ptr_q     <= PTR_W'(0);
            level_q      <= LVL_W'(0);
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
            left_q       <= 8'h00;
            right_q      <= 8'h00;
            stb_q        <= 1'b0;
            sreq_q       <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
`ifdef STE_SND_MONO_EN
            phase_q      <= 1'b0;
`endif
        end else begin
            sload_prev_q <= sload_prev_d;
            on_q         <= on_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            mem_q        <= mem_d;
            left_q       <= left_d;
            right_q      <= right_d;
            stb_q        <= stb_d;
            sreq_q       <= sreq_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
`ifdef STE_SND_MONO_EN
            phase_q      <= phase_d;
`endif
        end
    end

    assign sreq       = sreq_q;
    assign left       = left_q;
    assign right      = right_q;
    assign sample_stb = stb_q;
    assign level      = level_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_ste_snd_fifo.sv
// Directed bench for ste_snd_fifo (DEPTH=4, DIV_BASE=160) with a sample scoreboard.
module tb_ste_snd_fifo;
    logic        clk = 1'b0;
    logic        porb, sndon, mono, sload_n;
    logic [1:0]  rate;
    logic [15:0] data;
    logic        sreq, sample_stb, ovf, unf;
    logic [7:0]  left, right;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stb_cyc = 0;
    int e0, t_a, t_b, t_c;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    ste_snd_fifo #(.DEPTH(4), .DIV_BASE(160)) dut (
        .clk(clk), .porb(porb), .sndon(sndon), .mono(mono), .rate(rate),
        .sload_n(sload_n), .data(data), .sreq(sreq), .left(left), .right(right),
        .sample_stb(sample_stb), .level(level), .ovf(ovf), .unf(unf)
    );

    task automatic tick1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected samples are queued as {left,right} when the word is handed to the DUT.
    task automatic push_word(input logic [15:0] w, input bit kept);
        sload_n = 1'b0;
        data    = w;
        tick1();
        sload_n = 1'b1;
        data    = 16'h0000;
        tick1();
        if (kept) begin
`ifdef STE_SND_MONO_EN
            if (mono) begin
                sb.push_back({w[15:8], w[15:8]});
                sb.push_back({w[7:0], w[7:0]});
            end else begin
                sb.push_back(w);
            end
`else
            sb.push_back(w);
`endif
        end
    endtask

    task automatic wait_stb(input int budget);
        int n;
        logic [15:0] e;
        n = 0;
        do begin
            tick1();
            n++;
        end while (sample_stb !== 1'b1 && n < budget);
        check("stb_seen", 32'(sample_stb), 32'd1);
        if (sample_stb === 1'b1) begin
            stb_cyc = cyc;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("left", 32'(left), 32'(e[15:8]));
                check("right", 32'(right), 32'(e[7:0]));
            end
        end
    endtask

    initial begin
        porb = 1'b0; sndon = 1'b0; mono = 1'b0; rate = 2'd3; sload_n = 1'b1; data = 16'h0000;
        #23;
        check("rst_level", 32'(level), 32'd0);
        check("rst_sreq", 32'(sreq), 32'd0);
        check("rst_left", 32'(left), 32'd0);
        check("rst_right", 32'(right), 32'd0);
        check("rst_stb", 32'(sample_stb), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        porb = 1'b1;
        tick1();
        tick1();

        // Stereo word, first tick latency from the enabling edge.
        sndon = 1'b1; sload_n = 1'b0; data = 16'h7F80;
        tick1();
        e0 = cyc;
        sb.push_back(16'h7F80);
        sload_n = 1'b1; data = 16'h0000;
        check("sreq_on", 32'(sreq), 32'd1);
        check("level_push1", 32'(level), 32'd1);
        wait_stb(400);
        check("first_tick_lat", 32'(stb_cyc - e0), 32'd160);
        check("unf_clear", 32'(unf), 32'd0);
        check("level_after_pop", 32'(level), 32'd0);
        tick1();
        check("stb_one_cycle", 32'(sample_stb), 32'd0);

        // Empty FIFO at tick: hold samples, set unf, no strobe.
        repeat (158) tick1();
        check("unf_before_tick", 32'(unf), 32'd0);
        tick1();
        check("unf_set", 32'(unf), 32'd1);
        check("unf_no_stb", 32'(sample_stb), 32'd0);
        check("unf_hold_l", 32'(left), 32'h7F);
        check("unf_hold_r", 32'(right), 32'h80);

        // Mono: high byte then low byte from one word.
        mono = 1'b1;
        push_word(16'h1122, 1'b1);
        wait_stb(400);
`ifdef STE_SND_MONO_EN
        check("mono_level_h", 32'(level), 32'd1);
        wait_stb(400);
`endif
        check("mono_level_l", 32'(level), 32'd0);
        mono = 1'b0;

        // Overflow: five pushes with no intervening tick.
        push_word(16'hA1B2, 1'b1);
        push_word(16'hC3D4, 1'b1);
        check("sreq_lvl2", 32'(sreq), 32'd1);
        push_word(16'hE5F6, 1'b1);
        check("sreq_lvl3", 32'(sreq), 32'd0);
        check("level3", 32'(level), 32'd3);
        push_word(16'h0718, 1'b1);
        check("level4", 32'(level), 32'd4);
        check("ovf_not_yet", 32'(ovf), 32'd0);
        push_word(16'h99AA, 1'b0);
        check("level_full", 32'(level), 32'd4);
        check("ovf_set", 32'(ovf), 32'd1);
        repeat (4) wait_stb(400);
        check("level_drained", 32'(level), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        repeat (160) tick1();
        check("dropped_no_stb", 32'(sample_stb), 32'd0);
        check("dropped_hold_l", 32'(left), 32'h07);
        check("dropped_hold_r", 32'(right), 32'h18);

        // Rate 0 periods, then a mid-period switch to rate 2.
        rate = 2'd0;
        push_word(16'h1357, 1'b1);
        push_word(16'h2468, 1'b1);
        wait_stb(400);
        t_a = stb_cyc;
        wait_stb(1400);
        check("period_r0", 32'(stb_cyc - t_a), 32'd1280);
        t_b = stb_cyc;
        push_word(16'h3579, 1'b1);
        repeat (500) tick1();
        rate = 2'd2;
        push_word(16'h468A, 1'b1);
        wait_stb(1400);
        check("period_switch", 32'(stb_cyc - t_b), 32'd1280);
        t_c = stb_cyc;
        wait_stb(400);
        check("period_r2", 32'(stb_cyc - t_c), 32'd320);

        // Disable with words queued, ignored push, then re-enable.
        push_word(16'h1111, 1'b1);
        push_word(16'h2222, 1'b1);
        push_word(16'h3333, 1'b1);
        check("level_queued", 32'(level), 32'd3);
        sndon = 1'b0;
        tick1();
        sb.delete();
        check("off_level", 32'(level), 32'd0);
        check("off_left", 32'(left), 32'd0);
        check("off_right", 32'(right), 32'd0);
        check("off_sreq", 32'(sreq), 32'd0);
        check("off_ovf", 32'(ovf), 32'd0);
        check("off_unf", 32'(unf), 32'd0);
        sload_n = 1'b0; data = 16'hDEAD;
        tick1();
        sload_n = 1'b1; data = 16'h0000;
        tick1();
        check("off_push_ignored", 32'(level), 32'd0);
        sndon = 1'b1; sload_n = 1'b0; data = 16'h5A3C;
        tick1();
        e0 = cyc;
        sb.push_back(16'h5A3C);
        sload_n = 1'b1; data = 16'h0000;
        check("reon_sreq", 32'(sreq), 32'd1);
        check("reon_level", 32'(level), 32'd1);
        wait_stb(400);
        check("reon_latency", 32'(stb_cyc - e0), 32'd320);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
